// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA/game types: screen select enum and game-flow constants
package vga_pkg;

    // Screen select consumed by the screen mux.
    typedef enum logic [1:0] {
        START    = 2'd0,
        GAME     = 2'd1,
        PLAYER_1 = 2'd2,
        PLAYER_2 = 2'd3
    } state;

    localparam int SCORE_W                 = 3;
    localparam int WIN_SCORE_DEFAULT       = 3;
    localparam int WIN_HOLD_FRAMES_DEFAULT = 300;
    localparam int HOLDOFF_FRAMES_DEFAULT  = 30;

endpackage

// File: rtl/rise_det.sv
// rtl/rise_det.sv - single-cycle rising-edge detector
// Ports:
//   clk  in  clock
//   rst  in  synchronous active-high reset (clears the history register)
//   sig  in  level input
//   rise out sig & ~sig_q, combinational from the current input
module rise_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/screen_sequencer.sv
// rtl/screen_sequencer.sv - game-flow FSM: START -> GAME -> PLAYER_1/PLAYER_2 -> START
// Screen changes are committed only on a vsync rising edge. Optional pause
// feature is compiled in with `define GAME_PAUSE_EN.
// Ports:
//   clk        in  pixel clock
//   rst        in  synchronous active-high reset
//   vsync      in  vsync from VGA timing
//   btn_start  in  debounced start/confirm button (level)
//   p1_point   in  1-cycle pulse, player 1 scored
//   p2_point   in  1-cycle pulse, player 2 scored
//   screen     out committed screen select
//   score_p1   out player 1 score, saturating at WIN_SCORE
//   score_p2   out player 2 score, saturating at WIN_SCORE
//   game_rst   out 1-cycle pulse the cycle after screen first shows GAME
//   frame_tick out 1-cycle pulse on vsync rising edge
//   paused     out GAME paused (constant 0 without GAME_PAUSE_EN)
module screen_sequencer
    import vga_pkg::*;
#(
    parameter int WIN_SCORE       = WIN_SCORE_DEFAULT,
    parameter int WIN_HOLD_FRAMES = WIN_HOLD_FRAMES_DEFAULT,
    parameter int HOLDOFF_FRAMES  = HOLDOFF_FRAMES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vsync,
    input  logic               btn_start,
    input  logic               p1_point,
    input  logic               p2_point,
    output state               screen,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic               game_rst,
    output logic               frame_tick,
    output logic               paused
);

    localparam int HOLD_W = $clog2(WIN_HOLD_FRAMES);
    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(WIN_HOLD_FRAMES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_READY = HOLD_W'(HOLDOFF_FRAMES);

    logic               btn_rise;
    state               fsm_q, fsm_d;
    logic [SCORE_W-1:0] score_p1_d, score_p2_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               paused_q, paused_d;
    logic               enter_q;

    rise_det u_vsync_rise (
        .clk  (clk),
        .rst  (rst),
        .sig  (vsync),
        .rise (frame_tick)
    );

    rise_det u_btn_rise (
        .clk  (clk),
        .rst  (rst),
        .sig  (btn_start),
        .rise (btn_rise)
    );

    always_comb begin
        fsm_d      = fsm_q;
        score_p1_d = score_p1;
        score_p2_d = score_p2;
        hold_d     = hold_q;
        paused_d   = paused_q;
        case (fsm_q)
            START: begin
                if (btn_rise) begin
                    fsm_d      = GAME;
                    score_p1_d = '0;
                    score_p2_d = '0;
                end
            end
            GAME: begin
                // Gating uses the pause state held during this cycle, so a
                // point arriving with the pausing press still counts.
                if (!paused_q) begin
                    if (p1_point && score_p1 < WIN) score_p1_d = score_p1 + SCORE_W'(1);
                    if (p2_point && score_p2 < WIN) score_p2_d = score_p2 + SCORE_W'(1);
                    // Player 1 checked first: a simultaneous win goes to P1.
                    if (score_p1_d == WIN) begin
                        fsm_d  = PLAYER_1;
                        hold_d = '0;
                    end else if (score_p2_d == WIN) begin
                        fsm_d  = PLAYER_2;
                        hold_d = '0;
                    end
                end
`ifdef GAME_PAUSE_EN
                if (btn_rise) paused_d = ~paused_q;
                if (fsm_d != GAME) paused_d = 1'b0;
`else
                paused_d = 1'b0;
`endif
            end
            PLAYER_1, PLAYER_2: begin
                if (frame_tick) begin
                    if (hold_q == HOLD_LAST) fsm_d = START;
                    else                     hold_d = hold_q + HOLD_W'(1);
                end
                // Presses before the holdoff window are simply dropped.
                if (btn_rise && hold_q >= HOLD_READY) fsm_d = START;
            end
            default: fsm_d = START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q    <= START;
            screen   <= START;
            score_p1 <= '0;
            score_p2 <= '0;
            hold_q   <= '0;
            paused_q <= 1'b0;
            enter_q  <= 1'b0;
            game_rst <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            score_p1 <= score_p1_d;
            score_p2 <= score_p2_d;
            hold_q   <= hold_d;
            paused_q <= paused_d;
            // Only the state present at the tick is committed to the display.
            if (frame_tick) screen <= fsm_q;
            // enter_q marks the commit into GAME; game_rst follows one cycle
            // after screen first shows GAME.
            enter_q  <= frame_tick && (fsm_q == GAME) && (screen != GAME);
            game_rst <= enter_q;
        end
    end

    assign paused = paused_q;

endmodule
